// File: rtl/draw_layer_sched_if.sv
// Pixel/layer bus between the scan and layer generators and the compositor.
// The slave side is the compositor; the master side drives pixel position, layers and config.
interface draw_layer_sched_if #(
    parameter int NUM_LAYERS = 4
);
    logic [9:0]               row;
    logic [9:0]               col;
    logic [NUM_LAYERS-1:0]    layer_hit;
    logic [24*NUM_LAYERS-1:0] layer_rgb;
    logic [NUM_LAYERS-1:0]    cfg_enable;
    logic [NUM_LAYERS-1:0]    cfg_blink;
    logic                     cfg_write;
    logic                     cfg_pending;
    logic [7:0]               red;
    logic [7:0]               green;
    logic [7:0]               blue;
    logic                     frame_start;
    logic [15:0]              frame_count;

    modport master (
        output row, col, layer_hit, layer_rgb, cfg_enable, cfg_blink, cfg_write,
        input  cfg_pending, red, green, blue, frame_start, frame_count
    );

    modport slave (
        input  row, col, layer_hit, layer_rgb, cfg_enable, cfg_blink, cfg_write,
        output cfg_pending, red, green, blue, frame_start, frame_count
    );
endinterface

// File: rtl/draw_layer_sched.sv
// Per-pixel layer compositor with frame-boundary sequencing: frame pulse/counter,
// double-buffered layer enable/blink config and a frame-based blink timer.
module draw_layer_sched #(
    parameter int NUM_LAYERS   = 4,
    parameter int BLINK_FRAMES = 30,
    parameter int H_ACTIVE     = 800,
    parameter int V_ACTIVE     = 600
) (
    input  logic                  clock,
    input  logic                  reset,
    draw_layer_sched_if.slave     bus
);
    localparam int         CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [9:0] ROW_LIM = 10'(V_ACTIVE);
    localparam logic [9:0] COL_LIM = 10'(H_ACTIVE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [NUM_LAYERS-1:0] act_en, act_blink;
    logic [NUM_LAYERS-1:0] stg_en, stg_blink;
    logic                  pending;
    logic                  phase;
    logic [CNT_W-1:0]      blink_cnt;
    logic [15:0]           frame_cnt;
    logic                  frame_pls;

    logic                  fb;
    logic                  in_area;
    logic [NUM_LAYERS-1:0] hit_eff;
    logic [23:0]           rgb_p0;
    logic [23:0]           rgb_p1;

    // Lowest-index claiming layer wins; scanning downward lets it overwrite higher ones.
    function automatic logic [23:0] pick_rgb(input logic [NUM_LAYERS-1:0] hit,
                                             input logic [24*NUM_LAYERS-1:0] rgb);
        logic [23:0] sel;
        sel = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (hit[i]) sel = rgb[24*i +: 24];
        end
        return sel;
    endfunction

    // Stage p0: boundary detect, effective hits and colour select
    always_comb begin
        fb      = (bus.row == ROW_LIM) && (bus.col == 10'd0);
        in_area = (bus.row < ROW_LIM) && (bus.col < COL_LIM);
        hit_eff = bus.layer_hit & act_en & (~act_blink | {NUM_LAYERS{phase}});
        rgb_p0  = in_area ? pick_rgb(hit_eff, bus.layer_rgb) : 24'h0;
    end

    // Stage p1: registered colour and frame-level state
    always_ff @(posedge clock) begin
        if (reset) begin
            rgb_p1    <= '0;
            frame_pls <= 1'b0;
            frame_cnt <= '0;
            pending   <= 1'b0;
            act_en    <= '1;
            stg_en    <= '1;
            act_blink <= '0;
            stg_blink <= '0;
            phase     <= 1'b1;
            blink_cnt <= '0;
        end else begin
            rgb_p1    <= rgb_p0;
            frame_pls <= fb;

            if (bus.cfg_write) begin
                stg_en    <= bus.cfg_enable;
                stg_blink <= bus.cfg_blink;
            end

            // A write landing on the boundary cycle still leaves new values pending.
            if (bus.cfg_write)
                pending <= 1'b1;
            else if (fb)
                pending <= 1'b0;

            if (fb) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (pending) begin
                    act_en    <= stg_en;
                    act_blink <= stg_blink;
                end
                if (blink_cnt == CNT_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.red         = rgb_p1[23:16];
    assign bus.green       = rgb_p1[15:8];
    assign bus.blue        = rgb_p1[7:0];
    assign bus.frame_start = frame_pls;
    assign bus.frame_count = frame_cnt;
    assign bus.cfg_pending = pending;
endmodule

// File: tb/tb_draw_layer_sched.sv
// Scoreboard bench for draw_layer_sched: expected colours are queued as each pixel
// is driven and compared against the registered RGB one cycle later.
module tb_draw_layer_sched;
    logic clock;
    logic reset;
    int   total;
    int   bad;
    logic [23:0] sb_q[$];

    draw_layer_sched_if #(.NUM_LAYERS(4)) bus ();

    draw_layer_sched #(
        .NUM_LAYERS  (4),
        .BLINK_FRAMES(2),
        .H_ACTIVE    (800),
        .V_ACTIVE    (600)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic cycle(input logic [9:0] r, input logic [9:0] c, input logic [3:0] h,
                         input logic wr, input string tag, input logic [23:0] exp);
        logic [23:0] want;
        bus.row       = r;
        bus.col       = c;
        bus.layer_hit = h;
        bus.cfg_write = wr;
        sb_q.push_back(exp);
        @(posedge clock);
        #1;
        bus.cfg_write = 1'b0;
        want = sb_q.pop_front();
        chk(tag, 32'({bus.red, bus.green, bus.blue}), 32'(want));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bit vis;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.row = '0;
        bus.col = '0;
        bus.layer_hit = '0;
        bus.cfg_write = 1'b0;
        bus.cfg_enable = '0;
        bus.cfg_blink = '0;
        bus.layer_rgb = {24'h00FF00, 24'h123456, 24'hFF0000, 24'h0000FF};

        repeat (2) @(posedge clock);
        #1;
        chk("rst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0);
        chk("rst_fs", 32'(bus.frame_start), 32'h0);
        chk("rst_count", 32'(bus.frame_count), 32'h0);
        chk("rst_pending", 32'(bus.cfg_pending), 32'h0);
        reset = 1'b0;

        // Priority and no-hit
        cycle(10, 10, 4'b1010, 1'b0, "prio_l1", 24'hFF0000);
        cycle(10, 10, 4'b0000, 1'b0, "no_hit", 24'h000000);

        // Active-area edges
        cycle(600, 5, 4'b0001, 1'b0, "row_out", 24'h000000);
        cycle(3, 800, 4'b0001, 1'b0, "col_out", 24'h000000);
        cycle(599, 799, 4'b0001, 1'b0, "last_px", 24'h0000FF);

        // Staged enable takes effect only after the boundary
        bus.cfg_enable = 4'b1110;
        bus.cfg_blink  = 4'b0000;
        cycle(100, 0, 4'b0001, 1'b1, "wr_px", 24'h0000FF);
        chk("pending_set", 32'(bus.cfg_pending), 32'h1);
        cycle(100, 1, 4'b0001, 1'b0, "l0_still", 24'h0000FF);
        cycle(600, 0, 4'b0011, 1'b0, "fb1_px", 24'h000000);
        chk("pending_clr", 32'(bus.cfg_pending), 32'h0);
        chk("fs_fb1", 32'(bus.frame_start), 32'h1);
        chk("count_1", 32'(bus.frame_count), 32'h1);
        cycle(0, 0, 4'b0011, 1'b0, "l0_off", 24'hFF0000);
        chk("fs_one_cycle", 32'(bus.frame_start), 32'h0);

        // Last write wins; write on boundary commits old staging and stays pending
        bus.cfg_enable = 4'b1100;
        cycle(5, 5, 4'b0000, 1'b1, "wr1", 24'h000000);
        bus.cfg_enable = 4'b1011;
        cycle(6, 5, 4'b0000, 1'b1, "wr2", 24'h000000);
        bus.cfg_enable = 4'b1111;
        cycle(600, 0, 4'b0000, 1'b1, "wr3_fb", 24'h000000);
        chk("pending_keep", 32'(bus.cfg_pending), 32'h1);
        cycle(1, 1, 4'b0100, 1'b0, "wr2_l2_off", 24'h000000);
        cycle(1, 2, 4'b0001, 1'b0, "wr2_l0_on", 24'h0000FF);
        cycle(600, 0, 4'b0000, 1'b0, "fb3", 24'h000000);
        chk("pending_clr3", 32'(bus.cfg_pending), 32'h0);
        cycle(1, 1, 4'b0100, 1'b0, "wr3_l2_on", 24'h123456);

        // Blink: two frames visible, two black
        do_reset();
        bus.cfg_enable = 4'b1111;
        bus.cfg_blink  = 4'b0001;
        cycle(0, 0, 4'b0001, 1'b1, "blink_wr", 24'h0000FF);
        for (int n = 1; n <= 8; n++) begin
            cycle(600, 0, 4'b0001, 1'b0, "blink_fb", 24'h000000);
            chk("blink_fs_hi", 32'(bus.frame_start), 32'h1);
            vis = ((n / 2) % 2) == 0;
            cycle(10, 10, 4'b0001, 1'b0, "blink_px", vis ? 24'h0000FF : 24'h000000);
            chk("blink_fs_lo", 32'(bus.frame_start), 32'h0);
            cycle(599, 799, 4'b0001, 1'b0, "blink_px2", vis ? 24'h0000FF : 24'h000000);
        end
        chk("count_8", 32'(bus.frame_count), 32'h8);

        // Run the frame counter up to its wrap point
        bus.row = 10'd600;
        bus.col = 10'd0;
        bus.layer_hit = 4'b0000;
        repeat (65535 - 8) @(posedge clock);
        #1;
        chk("count_ffff", 32'(bus.frame_count), 32'hFFFF);
        cycle(600, 0, 4'b0000, 1'b0, "wrap_fb", 24'h000000);
        chk("count_wrap", 32'(bus.frame_count), 32'h0);
        cycle(600, 0, 4'b0000, 1'b0, "post_wrap_fb", 24'h000000);
        chk("count_after_wrap", 32'(bus.frame_count), 32'h1);

        // Mid-frame reset discards staged config
        bus.cfg_enable = 4'b0000;
        bus.cfg_blink  = 4'b1111;
        cycle(50, 50, 4'b0000, 1'b1, "stage_wr", 24'h000000);
        chk("stage_pending", 32'(bus.cfg_pending), 32'h1);
        cycle(50, 51, 4'b0010, 1'b0, "pre_rst", 24'hFF0000);
        reset = 1'b1;
        bus.row = 10'd50;
        bus.col = 10'd52;
        bus.layer_hit = 4'b0010;
        @(posedge clock);
        #1;
        chk("mid_rst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0);
        chk("mid_rst_pending", 32'(bus.cfg_pending), 32'h0);
        chk("mid_rst_count", 32'(bus.frame_count), 32'h0);
        chk("mid_rst_fs", 32'(bus.frame_start), 32'h0);
        reset = 1'b0;
        cycle(600, 0, 4'b0000, 1'b0, "post_rst_fb", 24'h000000);
        chk("post_rst_pending", 32'(bus.cfg_pending), 32'h0);
        cycle(1, 1, 4'b1000, 1'b0, "en_all_ones", 24'h00FF00);
        cycle(1, 2, 4'b0010, 1'b0, "blink_zero", 24'hFF0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
